// File: rtl/mul_float_unpack_mantissa_mul_if.sv
// Operand/result bus of the FP multiplier front-end stage.
interface mul_float_unpack_mantissa_mul_if;
  // Upstream operand channel
  logic        iDATA_VALID;
  logic        oDATA_BUSY;
  logic [31:0] iDATA_A;
  logic [31:0] iDATA_B;

  // Downstream sign/exp/fract/except channel
  logic        oDATA_VALID;
  logic        iDATA_BUSY;
  logic        oDATA_SIGN;
  logic [9:0]  oDATA_EXP;
  logic [47:0] oDATA_FRACT;
  logic        oDATA_EXCEPT_EXP_A0;
  logic        oDATA_EXCEPT_EXP_B0;
  logic        oDATA_EXCEPT_EXP_A1;
  logic        oDATA_EXCEPT_EXP_B1;
  logic        oDATA_EXCEPT_FRACT_A0;
  logic        oDATA_EXCEPT_FRACT_B0;

  // Stage side
  modport slave (
    input  iDATA_VALID, iDATA_A, iDATA_B, iDATA_BUSY,
    output oDATA_BUSY, oDATA_VALID, oDATA_SIGN, oDATA_EXP, oDATA_FRACT,
           oDATA_EXCEPT_EXP_A0, oDATA_EXCEPT_EXP_B0,
           oDATA_EXCEPT_EXP_A1, oDATA_EXCEPT_EXP_B1,
           oDATA_EXCEPT_FRACT_A0, oDATA_EXCEPT_FRACT_B0
  );

  // Environment side (drives operands and downstream stall)
  modport master (
    output iDATA_VALID, iDATA_A, iDATA_B, iDATA_BUSY,
    input  oDATA_BUSY, oDATA_VALID, oDATA_SIGN, oDATA_EXP, oDATA_FRACT,
           oDATA_EXCEPT_EXP_A0, oDATA_EXCEPT_EXP_B0,
           oDATA_EXCEPT_EXP_A1, oDATA_EXCEPT_EXP_B1,
           oDATA_EXCEPT_FRACT_A0, oDATA_EXCEPT_FRACT_B0
  );
endinterface

// File: rtl/mul_float_unpack_mantissa_mul.sv
// binary32 multiplier front-end: unpack operands, sum exponents, form the
// full 48-bit mantissa product and raw-field exception flags (2-stage pipe).
module mul_float_unpack_mantissa_mul (
  input  logic iCLOCK,
  input  logic inRESET,
  input  logic iRESET_SYNC,
  mul_float_unpack_mantissa_mul_if.slave bus
);

  localparam int unsigned EXP_W   = 8;
  localparam int unsigned FRAC_W  = 23;
  localparam int unsigned MANT_W  = FRAC_W + 1;
  localparam int unsigned EXPS_W  = 10;
  localparam int unsigned PROD_W  = 2 * MANT_W;
  localparam int unsigned FLAG_W  = 6;
  localparam int unsigned BIAS    = 127;

  // Flag vector order: {exp_a0, exp_b0, exp_a1, exp_b1, fract_a0, fract_b0}
  logic [EXP_W-1:0]  w_exp_a;
  logic [EXP_W-1:0]  w_exp_b;
  logic [FRAC_W-1:0] w_frac_a;
  logic [FRAC_W-1:0] w_frac_b;
  logic [MANT_W-1:0] w_mant_a;
  logic [MANT_W-1:0] w_mant_b;
  logic              w_sign;
  logic [EXPS_W-1:0] w_exp_sum;
  logic [FLAG_W-1:0] w_flags;
  logic [PROD_W-1:0] w_product;
  logic              w_advance;

  logic              r_s1_valid;
  logic              r_s1_sign;
  logic [EXPS_W-1:0] r_s1_exp;
  logic [MANT_W-1:0] r_s1_mant_a;
  logic [MANT_W-1:0] r_s1_mant_b;
  logic [FLAG_W-1:0] r_s1_flags;

  logic              r_s2_valid;
  logic              r_s2_sign;
  logic [EXPS_W-1:0] r_s2_exp;
  logic [PROD_W-1:0] r_s2_fract;
  logic [FLAG_W-1:0] r_s2_flags;

  assign w_exp_a  = bus.iDATA_A[30:23];
  assign w_exp_b  = bus.iDATA_B[30:23];
  assign w_frac_a = bus.iDATA_A[22:0];
  assign w_frac_b = bus.iDATA_B[22:0];

  // Hidden bit is cleared for a zero exponent (zero / subnormal operands)
  assign w_mant_a  = {(|w_exp_a), w_frac_a};
  assign w_mant_b  = {(|w_exp_b), w_frac_b};
  assign w_sign    = bus.iDATA_A[31] ^ bus.iDATA_B[31];

  // Wraps mod 1024 on purpose; the normalize stage decodes under/overflow
  assign w_exp_sum = EXPS_W'({2'b00, w_exp_a}) + EXPS_W'({2'b00, w_exp_b})
                   - EXPS_W'(BIAS);

  assign w_flags = {(w_exp_a == 8'h00), (w_exp_b == 8'h00),
                    (w_exp_a == 8'hFF), (w_exp_b == 8'hFF),
                    (w_frac_a == 23'd0), (w_frac_b == 23'd0)};

  assign w_product = PROD_W'(r_s1_mant_a) * PROD_W'(r_s1_mant_b);
  assign w_advance = ~bus.iDATA_BUSY;

  // Stage 1: unpacked operands; bubbles propagate, payload loads regardless of valid
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_s1_valid  <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_exp    <= '0;
      r_s1_mant_a <= '0;
      r_s1_mant_b <= '0;
      r_s1_flags  <= '0;
    end else if (iRESET_SYNC) begin
      r_s1_valid  <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_exp    <= '0;
      r_s1_mant_a <= '0;
      r_s1_mant_b <= '0;
      r_s1_flags  <= '0;
    end else if (w_advance) begin
      r_s1_valid  <= bus.iDATA_VALID;
      r_s1_sign   <= w_sign;
      r_s1_exp    <= w_exp_sum;
      r_s1_mant_a <= w_mant_a;
      r_s1_mant_b <= w_mant_b;
      r_s1_flags  <= w_flags;
    end
  end

  // Stage 2: mantissa product, with sign/exp/flags carried alongside
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_s2_valid <= 1'b0;
      r_s2_sign  <= 1'b0;
      r_s2_exp   <= '0;
      r_s2_fract <= '0;
      r_s2_flags <= '0;
    end else if (iRESET_SYNC) begin
      r_s2_valid <= 1'b0;
      r_s2_sign  <= 1'b0;
      r_s2_exp   <= '0;
      r_s2_fract <= '0;
      r_s2_flags <= '0;
    end else if (w_advance) begin
      r_s2_valid <= r_s1_valid;
      r_s2_sign  <= r_s1_sign;
      r_s2_exp   <= r_s1_exp;
      r_s2_fract <= w_product;
      r_s2_flags <= r_s1_flags;
    end
  end

  // Stall passes straight through to upstream
  assign bus.oDATA_BUSY = bus.iDATA_BUSY;

  assign bus.oDATA_VALID           = r_s2_valid;
  assign bus.oDATA_SIGN            = r_s2_sign;
  assign bus.oDATA_EXP             = r_s2_exp;
  assign bus.oDATA_FRACT           = r_s2_fract;
  assign bus.oDATA_EXCEPT_EXP_A0   = r_s2_flags[5];
  assign bus.oDATA_EXCEPT_EXP_B0   = r_s2_flags[4];
  assign bus.oDATA_EXCEPT_EXP_A1   = r_s2_flags[3];
  assign bus.oDATA_EXCEPT_EXP_B1   = r_s2_flags[2];
  assign bus.oDATA_EXCEPT_FRACT_A0 = r_s2_flags[1];
  assign bus.oDATA_EXCEPT_FRACT_B0 = r_s2_flags[0];

endmodule

// File: tb/tb_mul_float_unpack_mantissa_mul.sv
// Directed bench for the FP multiplier front-end stage.
module tb_mul_float_unpack_mantissa_mul;

  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [47:0] fract;
    logic [5:0]  flags;   // {exp_a0, exp_b0, exp_a1, exp_b1, fract_a0, fract_b0}
  } res_t;

  typedef struct {
    string       tag;
    logic [31:0] a;
    logic [31:0] b;
    res_t        e;
  } vec_t;

  logic clk;
  logic rst_n;
  logic rsync;
  int   n_vec;
  int   n_err;

  mul_float_unpack_mantissa_mul_if bus ();

  mul_float_unpack_mantissa_mul dut (
    .iCLOCK      (clk),
    .inRESET     (rst_n),
    .iRESET_SYNC (rsync),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] obs_flags();
    return {bus.oDATA_EXCEPT_EXP_A0, bus.oDATA_EXCEPT_EXP_B0,
            bus.oDATA_EXCEPT_EXP_A1, bus.oDATA_EXCEPT_EXP_B1,
            bus.oDATA_EXCEPT_FRACT_A0, bus.oDATA_EXCEPT_FRACT_B0};
  endfunction

  // Reference: straight from the binary32 field definitions
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
    res_t r;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [23:0] ma;
    logic [23:0] mb;
    ea = a[30:23];
    eb = b[30:23];
    ma = {(ea != 8'd0), a[22:0]};
    mb = {(eb != 8'd0), b[22:0]};
    r.sign  = a[31] ^ b[31];
    r.exp   = 10'(int'(ea) + int'(eb) - 127);
    r.fract = 48'(ma) * 48'(mb);
    r.flags = {(ea == 8'h00), (eb == 8'h00), (ea == 8'hFF), (eb == 8'hFF),
               (a[22:0] == 23'd0), (b[22:0] == 23'd0)};
    return r;
  endfunction

  task automatic check_res(input string tag, input res_t e);
    check({tag, "_valid"}, 64'(bus.oDATA_VALID), 64'(1'b1));
    check({tag, "_sign"},  64'(bus.oDATA_SIGN),  64'(e.sign));
    check({tag, "_exp"},   64'(bus.oDATA_EXP),   64'(e.exp));
    check({tag, "_fract"}, 64'(bus.oDATA_FRACT), 64'(e.fract));
    check({tag, "_flags"}, 64'(obs_flags()),     64'(e.flags));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 64'(bus.oDATA_VALID), 64'(0));
    check({tag, "_sign"},  64'(bus.oDATA_SIGN),  64'(0));
    check({tag, "_exp"},   64'(bus.oDATA_EXP),   64'(0));
    check({tag, "_fract"}, 64'(bus.oDATA_FRACT), 64'(0));
    check({tag, "_flags"}, 64'(obs_flags()),     64'(0));
  endtask

  // Single operand pair followed by a bubble; result read 2 edges later
  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input res_t e);
    @(negedge clk);
    bus.iDATA_VALID = 1'b1;
    bus.iDATA_A     = a;
    bus.iDATA_B     = b;
    @(negedge clk);
    bus.iDATA_VALID = 1'b0;
    bus.iDATA_A     = $urandom;
    bus.iDATA_B     = $urandom;
    @(negedge clk);
    check_res(tag, e);
  endtask

  task automatic idle_check(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check({tag, "_novalid"}, 64'(bus.oDATA_VALID), 64'(0));
    end
  endtask

  vec_t        dir [8];
  logic [31:0] pa  [8];
  logic [31:0] pb  [8];
  res_t        q   [$];
  res_t        e0;
  res_t        e1;
  int          send;
  int          got;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    rsync = 1'b0;
    bus.iDATA_VALID = 1'b0;
    bus.iDATA_BUSY  = 1'b0;
    bus.iDATA_A     = 32'h3F80_0000;
    bus.iDATA_B     = 32'h3F80_0000;

    // Reset state, busy passthrough during reset
    #12;
    check_zero("reset");
    bus.iDATA_BUSY = 1'b1;
    #1 check("reset_busy_hi", 64'(bus.oDATA_BUSY), 64'(1));
    bus.iDATA_BUSY = 1'b0;
    #1 check("reset_busy_lo", 64'(bus.oDATA_BUSY), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Hand-computed directed vectors
    dir[0] = '{"one_x_one",   32'h3F80_0000, 32'h3F80_0000, '{1'b0, 10'h07F, 48'h4000_0000_0000, 6'b000011}};
    dir[1] = '{"m2_x_3",      32'hC000_0000, 32'h4040_0000, '{1'b1, 10'h081, 48'h6000_0000_0000, 6'b000010}};
    dir[2] = '{"1p5_x_1p5",   32'h3FC0_0000, 32'h3FC0_0000, '{1'b0, 10'h07F, 48'h9000_0000_0000, 6'b000000}};
    dir[3] = '{"zero_x_one",  32'h0000_0000, 32'h3F80_0000, '{1'b0, 10'h000, 48'h0000_0000_0000, 6'b100011}};
    dir[4] = '{"inf_x_nan",   32'h7F80_0000, 32'h7FC0_0000, '{1'b0, 10'h17F, 48'h6000_0000_0000, 6'b001110}};
    dir[5] = '{"minn_x_minn", 32'h0080_0000, 32'h0080_0000, '{1'b0, 10'h383, 48'h4000_0000_0000, 6'b000011}};
    dir[6] = '{"sub_x_one",   32'h0040_0000, 32'h3F80_0000, '{1'b0, 10'h000, 48'h2000_0000_0000, 6'b100001}};
    dir[7] = '{"max_x_max",   32'hFF7F_FFFF, 32'h7F7F_FFFF, '{1'b1, 10'h17D, 48'hFFFF_FE00_0001, 6'b000000}};
    foreach (dir[i]) run_one(dir[i].tag, dir[i].a, dir[i].b, dir[i].e);

    // Back-to-back stream of 8 random pairs: results on 8 consecutive cycles
    foreach (pa[i]) begin
      pa[i] = $urandom;
      pb[i] = $urandom;
    end
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (c >= 2 && c < 10) check_res($sformatf("stream%0d", c - 2), model(pa[c-2], pb[c-2]));
      if (c == 10) check("stream_end", 64'(bus.oDATA_VALID), 64'(0));
      bus.iDATA_VALID = (c < 8);
      if (c < 8) begin
        bus.iDATA_A = pa[c];
        bus.iDATA_B = pb[c];
      end
    end

    // Stall with two results in flight; junk presented during busy is ignored
    e0 = model(32'hC0A0_0000, 32'h3E40_0000);
    e1 = model(32'h4120_0000, 32'hBF00_0001);
    @(negedge clk);
    bus.iDATA_VALID = 1'b1;
    bus.iDATA_A = 32'hC0A0_0000; bus.iDATA_B = 32'h3E40_0000;
    @(negedge clk);
    bus.iDATA_A = 32'h4120_0000; bus.iDATA_B = 32'hBF00_0001;
    @(negedge clk);
    check_res("hold_pre", e0);
    bus.iDATA_BUSY = 1'b1;
    bus.iDATA_A = 32'h7F80_0000; bus.iDATA_B = 32'h0000_0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_res($sformatf("hold%0d", i), e0);
      check($sformatf("hold%0d_busy", i), 64'(bus.oDATA_BUSY), 64'(1));
    end
    bus.iDATA_BUSY  = 1'b0;
    bus.iDATA_VALID = 1'b0;
    @(negedge clk);
    check_res("hold_second", e1);
    @(negedge clk);
    check("hold_after", 64'(bus.oDATA_VALID), 64'(0));

    // Busy toggling each cycle: every result delivered once, in order
    foreach (pa[i]) begin
      pa[i] = $urandom;
      pb[i] = $urandom;
    end
    q.delete();
    send = 0;
    got  = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      bus.iDATA_BUSY = c[0];
      #1;
      if (bus.oDATA_VALID && !bus.iDATA_BUSY) begin
        if (q.size() == 0) begin
          check("toggle_extra", 64'(1), 64'(0));
        end else begin
          check_res($sformatf("toggle%0d", got), q.pop_front());
        end
        got++;
      end
      bus.iDATA_VALID = (send < 8);
      if (send < 8) begin
        bus.iDATA_A = pa[send];
        bus.iDATA_B = pb[send];
        if (!bus.iDATA_BUSY) begin
          q.push_back(model(pa[send], pb[send]));
          send++;
        end
      end
    end
    check("toggle_count", 64'(got), 64'(8));
    bus.iDATA_BUSY  = 1'b0;
    bus.iDATA_VALID = 1'b0;
    idle_check("toggle_drain", 2);

    // Async reset with two entries in flight
    @(negedge clk);
    bus.iDATA_VALID = 1'b1;
    bus.iDATA_A = 32'hC2F6_E979; bus.iDATA_B = 32'hFF7F_FFFF;
    @(negedge clk);
    bus.iDATA_A = 32'h3F80_0001; bus.iDATA_B = 32'h7F80_0000;
    @(negedge clk);
    check("pre_areset_valid", 64'(bus.oDATA_VALID), 64'(1));
    rst_n = 1'b0;
    bus.iDATA_VALID = 1'b0;
    #1 check_zero("areset");
    @(negedge clk);
    rst_n = 1'b1;
    idle_check("post_areset", 3);
    run_one("post_areset_first", 32'h4000_0000, 32'h4000_0000,
            '{1'b0, 10'h081, 48'h4000_0000_0000, 6'b000011});

    // Synchronous clear overrides busy and discards in-flight data
    @(negedge clk);
    bus.iDATA_VALID = 1'b1;
    bus.iDATA_A = 32'hC2F6_E979; bus.iDATA_B = 32'hFF7F_FFFF;
    @(negedge clk);
    bus.iDATA_A = 32'h3F80_0001; bus.iDATA_B = 32'h7F80_0000;
    @(negedge clk);
    rsync = 1'b1;
    bus.iDATA_BUSY  = 1'b1;
    bus.iDATA_VALID = 1'b0;
    @(negedge clk);
    rsync = 1'b0;
    bus.iDATA_BUSY = 1'b0;
    check_zero("sreset");
    idle_check("post_sreset", 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
